// File: rtl/wb_data_ram_slave.sv
// Wishbone classic-cycle data RAM responder for the OpenMIPS data bus.
// Word-organised RAM with byte-lane writes, optional wait states and an
// error termination for addresses outside the RAM window.
module wb_data_ram_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_LOG2  = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Counter preload when leaving IDLE; unused when there are no wait states.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg, cnt_next;
  logic                    accept;

  // Fields captured when a request is accepted.
  logic [DEPTH_LOG2-1:0]   idx_reg;
  logic                    ok_reg;
  logic                    we_reg;
  logic [3:0]              sel_reg;
  logic [31:0]             dat_reg;

  logic                    request;
  logic [ADDR_WIDTH-3:0]   word_off;
  logic                    cur_in_range;
  logic [DEPTH_LOG2-1:0]   cur_idx;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic                    rd_en;
  logic                    wr_en;
  logic                    resp;
  logic [31:0]             rd_word;
  logic [31:0]             lane_mask;

  assign request = wb_cyc_i & wb_stb_i;

  // Word offset from the window base; BASE_ADDR is word aligned, so the
  // byte-offset bits never influence the index.
  assign word_off     = wb_adr_i[ADDR_WIDTH-1:2] - BASE_ADDR[ADDR_WIDTH-1:2];
  assign cur_in_range = (wb_adr_i >= BASE_ADDR) &&
                        (word_off[ADDR_WIDTH-3:DEPTH_LOG2] == '0);
  assign cur_idx      = word_off[DEPTH_LOG2-1:0];

  // Next-state logic: accept in IDLE, count down in WAIT, one-cycle RESP.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (request) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!request) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (cnt_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Capture the request so WAIT/RESP do not depend on the master holding it.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_reg <= cur_idx;
      ok_reg  <= cur_in_range;
      we_reg  <= wb_we_i;
      sel_reg <= wb_sel_i;
      dat_reg <= wb_dat_i;
    end
  end

  // Read on the edge entering RESP; in IDLE the index is not yet latched.
  assign rd_idx = (state_reg == IDLE) ? cur_idx : idx_reg;
  assign rd_en  = (state_next == RESP);
  // Commit on the edge leaving RESP unless reset is asserted on that edge.
  assign wr_en  = rst && (state_reg == RESP) && ok_reg && we_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    // One byte lane of the RAM: byte-enabled write, registered read.
    always_ff @(posedge clk) begin
      if (wr_en && sel_reg[gi]) begin
        mem[idx_reg] <= dat_reg[gi*8 +: 8];
      end
      if (rd_en) begin
        rd_q <= mem[rd_idx];
      end
    end

    assign rd_word[gi*8 +: 8]   = rd_q;
    assign lane_mask[gi*8 +: 8] = {8{sel_reg[gi]}};
  end

  assign resp     = (state_reg == RESP);
  assign wb_ack_o = resp & ok_reg;
  assign wb_err_o = resp & ~ok_reg;
  assign wb_dat_o = (resp && ok_reg && !we_reg) ? (rd_word & lane_mask) : 32'h0;

endmodule

// File: tb/tb_wb_data_ram_slave.sv
// Self-checking bench: two responders (no wait states / three wait states)
// share one driven bus; a scoreboard queue holds the expected terminations.
module tb_wb_data_ram_slave;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE3 = 32'h0000_1000;
  localparam int          DEPTH = 1024;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic        chk_dat;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat = '0;
  logic [3:0]  sel = '0;
  int          which = 0;

  logic        cyc0, stb0, cyc3, stb3;
  logic [31:0] dat_o0, dat_o3, dat_m;
  logic        ack0, err0, ack3, err3, ack_m, err_m;

  exp_t        sb[$];
  logic [31:0] model [int];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  assign cyc0  = cyc & (which == 0);
  assign stb0  = stb & (which == 0);
  assign cyc3  = cyc & (which == 3);
  assign stb3  = stb & (which == 3);
  assign ack_m = (which == 0) ? ack0 : ack3;
  assign err_m = (which == 0) ? err0 : err3;
  assign dat_m = (which == 0) ? dat_o0 : dat_o3;

  wb_data_ram_slave #(.ADDR_WIDTH(32), .DEPTH_LOG2(10), .BASE_ADDR(BASE0), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc0), .wb_stb_i(stb0), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat),
    .wb_dat_o(dat_o0), .wb_ack_o(ack0), .wb_err_o(err0)
  );

  wb_data_ram_slave #(.ADDR_WIDTH(32), .DEPTH_LOG2(10), .BASE_ADDR(BASE3), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc3), .wb_stb_i(stb3), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat),
    .wb_dat_o(dat_o3), .wb_ack_o(ack3), .wb_err_o(err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] base_of();
    return (which == 0) ? BASE0 : BASE3;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= base_of()) && (((a - base_of()) >> 2) < DEPTH);
  endfunction

  function automatic int key_of(input logic [31:0] a);
    return which * 65536 + int'((a - base_of()) >> 2);
  endfunction

  function automatic logic [31:0] mask_of(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{s[i]}};
    return m;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int k;
    k = key_of(a);
    return model.exists(k) ? model[k] : 32'hxxxx_xxxx;
  endfunction

  // One transaction: push expectation, drive, wait for termination, compare.
  // Called right after a falling edge; returns right after a falling edge.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d);
    exp_t e;
    int   n;
    bit   got;
    e.ack     = in_rng(a);
    e.err     = !e.ack;
    e.chk_dat = !w;
    e.dat     = (!w && e.ack) ? (model_rd(a) & mask_of(s)) : 32'h0;
    e.lat     = which + 1;
    sb.push_back(e);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (ack_m || err_m) got = 1'b1;
    end
    e = sb.pop_front();
    if (!got) begin
      check("timeout", 32'(n), 32'(e.lat));
    end else begin
      $display("xfer dut%0d %s adr=%h sel=%h ack=%0b err=%0b dat=%h lat=%0d",
               which, w ? "WR" : "RD", a, s, ack_m, err_m, dat_m, n);
      check("ack", 32'(ack_m), 32'(e.ack));
      check("err", 32'(err_m), 32'(e.err));
      check("latency", 32'(n), 32'(e.lat));
      if (e.chk_dat) check("rdata", dat_m, e.dat);
      if (w && e.ack) model[key_of(a)] = (model_rd(a) & ~mask_of(s)) | (d & mask_of(s));
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("pulse_ack", 32'(ack_m), 32'h0);
    check("pulse_err", 32'(err_m), 32'h0);
    check("idle_dat", dat_m, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a request pending: no response may appear.
    which = 0;
    rst = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE0 + 32'h40; sel = 4'hF; dat = 32'hCAFE_F00D;
    repeat (3) begin
      @(negedge clk);
      check("rst_ack", 32'(ack0 | ack3), 32'h0);
      check("rst_err", 32'(err0 | err3), 32'h0);
      check("rst_dat", dat_o0 | dat_o3, 32'h0);
    end
    rst = 1'b1;
    xfer(1'b1, BASE0 + 32'h40, 4'hF, 32'hCAFE_F00D);
    xfer(1'b0, BASE0 + 32'h40, 4'hF, 32'h0);

    // Full word, no wait states.
    xfer(1'b1, BASE0 + 32'h10, 4'hF, 32'hDEAD_BEEF);
    xfer(1'b0, BASE0 + 32'h10, 4'hF, 32'h0);

    // Byte lanes.
    xfer(1'b1, BASE0 + 32'h20, 4'hF, 32'h1122_3344);
    xfer(1'b1, BASE0 + 32'h20, 4'b0101, 32'hAABB_CCDD);
    xfer(1'b0, BASE0 + 32'h20, 4'hF, 32'h0);
    xfer(1'b0, BASE0 + 32'h20, 4'b0011, 32'h0);
    xfer(1'b1, BASE0 + 32'h24, 4'hF, 32'h0102_0304);
    xfer(1'b1, BASE0 + 32'h24, 4'b0000, 32'hFFFF_FFFF);
    xfer(1'b0, BASE0 + 32'h24, 4'b1000, 32'h0);
    xfer(1'b0, BASE0 + 32'h24, 4'hF, 32'h0);

    // Out of range above the window; word 0 must survive.
    xfer(1'b1, BASE0, 4'hF, 32'hA5A5_5A5A);
    xfer(1'b1, BASE0 + 32'h1000, 4'hF, 32'h5555_5555);
    xfer(1'b0, BASE0 + 32'h1000, 4'hF, 32'h0);
    xfer(1'b0, BASE0, 4'hF, 32'h0);
    xfer(1'b1, BASE0 + 32'hFFC, 4'hF, 32'h7777_0001);
    xfer(1'b0, BASE0 + 32'hFFC, 4'hF, 32'h0);

    // Reset while in RESP during a write: write discarded.
    xfer(1'b1, BASE0 + 32'h80, 4'hF, 32'h1234_5678);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE0 + 32'h80; sel = 4'hF; dat = 32'hFFFF_0000;
    @(negedge clk);
    check("resp_ack_before_rst", 32'(ack_m), 32'h1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_resp_ack", 32'(ack_m), 32'h0);
    check("rst_resp_err", 32'(err_m), 32'h0);
    cyc = 1'b0; stb = 1'b0; rst = 1'b1;
    @(negedge clk);
    xfer(1'b0, BASE0 + 32'h80, 4'hF, 32'h0);

    // Three wait states, base at 0x1000.
    which = 3;
    xfer(1'b1, BASE3 + 32'h10, 4'hF, 32'h0BAD_CAFE);
    xfer(1'b0, BASE3 + 32'h10, 4'hF, 32'h0);
    xfer(1'b0, BASE3 - 32'h4, 4'hF, 32'h0);
    xfer(1'b1, BASE3 + 32'h1000, 4'hF, 32'h1);
    xfer(1'b1, BASE3 + 32'hFFC, 4'b1100, 32'hBEEF_0000);
    xfer(1'b1, BASE3 + 32'hFFC, 4'b0011, 32'h0000_1357);
    xfer(1'b0, BASE3 + 32'hFFC, 4'hF, 32'h0);

    // Abort: strobe dropped while waiting, write must not happen.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE3 + 32'h10; sel = 4'hF; dat = 32'h9999_9999;
    @(negedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_resp", 32'(ack_m | err_m), 32'h0);
    end
    xfer(1'b0, BASE3 + 32'h10, 4'hF, 32'h0);

    // Reset while in WAIT during a write.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE3 + 32'h10; sel = 4'hF; dat = 32'h4444_4444;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_wait_ack", 32'(ack_m), 32'h0);
    check("rst_wait_err", 32'(err_m), 32'h0);
    cyc = 1'b0; stb = 1'b0; rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_wait_quiet", 32'(ack_m | err_m), 32'h0);
    end
    xfer(1'b0, BASE3 + 32'h10, 4'hF, 32'h0);
    xfer(1'b1, BASE3 + 32'h14, 4'hF, 32'h2468_ACE0);
    xfer(1'b0, BASE3 + 32'h14, 4'b0110, 32'h0);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
